// File: rtl/ext_irq_ctrl_if.sv
// ext_irq_ctrl_if: source, config and core-handshake signals of the external interrupt controller
interface ext_irq_ctrl_if #(parameter int N_SRC = 16);
  logic [N_SRC-1:0] src_i;
  logic             cfg_we_i;
  logic [5:0]       cfg_addr_i;
  logic [31:0]      cfg_wdata_i;
  logic [31:0]      cfg_rdata_o;
  logic             irq_ack_i;
  logic             complete_i;
  logic             meip_o;
  logic [4:0]       irq_id_o;
  logic [N_SRC-1:0] pending_o;
  modport master (output src_i, cfg_we_i, cfg_addr_i, cfg_wdata_i, irq_ack_i, complete_i,
                  input cfg_rdata_o, meip_o, irq_id_o, pending_o);
  modport slave  (input src_i, cfg_we_i, cfg_addr_i, cfg_wdata_i, irq_ack_i, complete_i,
                  output cfg_rdata_o, meip_o, irq_id_o, pending_o);
endinterface

// File: rtl/ext_irq_ctrl.sv
// ext_irq_ctrl: priority-arbitrated external interrupt controller with edge/level sources
module ext_irq_ctrl #(
  parameter int N_SRC  = 16,
  parameter int PRIO_W = 3
) (
  input  logic            clk_i,
  input  logic            reset_i,
  ext_irq_ctrl_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, ASSERT, SERVICE} state_t;
  state_t r_state, w_next;
  logic [N_SRC-1:0]  r_en, r_mode, r_pend, r_src_q, w_elig, w_rise, w_clr;
  logic [PRIO_W-1:0] r_thr, w_best;
  logic [PRIO_W-1:0] r_prio [N_SRC];
  logic [4:0]        r_id, w_win;
  logic              w_any, w_id_elig, w_unused;
  logic [31:0]       r_rdata, w_rd;
  assign w_unused = ^bus.cfg_wdata_i;
  // ties go to the lowest index because only a strictly higher priority replaces the current best
  always_comb begin
    w_rise    = bus.src_i & ~r_src_q;
    w_elig    = '0;
    w_clr     = '0;
    w_any     = 1'b0;
    w_best    = '0;
    w_win     = '0;
    w_id_elig = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      w_elig[k] = r_pend[k] & r_en[k] & (r_prio[k] > r_thr);
      if (w_elig[k] && (!w_any || r_prio[k] > w_best)) begin
        w_any  = 1'b1;
        w_best = r_prio[k];
        w_win  = 5'(k);
      end
      if (r_id == 5'(k)) begin
        w_id_elig = w_elig[k];
        w_clr[k]  = (r_state == ASSERT) && bus.irq_ack_i;
      end
    end
  end
  always_comb begin
    w_rd = bus.cfg_addr_i == 6'h00 ? 32'(r_en)   :
           bus.cfg_addr_i == 6'h01 ? 32'(r_mode) :
           bus.cfg_addr_i == 6'h02 ? 32'(r_thr)  :
           bus.cfg_addr_i == 6'h03 ? 32'(r_pend) : 32'd0;
    for (int k = 0; k < N_SRC; k++)
      if (bus.cfg_addr_i == 6'(32 + k)) w_rd = 32'(r_prio[k]);
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_en    <= '0;
      r_mode  <= '0;
      r_thr   <= '0;
      r_pend  <= '0;
      r_src_q <= '0;
      r_rdata <= '0;
      r_id    <= '0;
      for (int k = 0; k < N_SRC; k++) r_prio[k] <= '0;
    end else begin
      r_src_q <= bus.src_i;
      r_pend  <= (r_mode & (w_rise | (r_pend & ~w_clr))) | (~r_mode & bus.src_i);
      r_rdata <= w_rd;
      if (r_state == IDLE && w_any) r_id <= w_win;
      if (bus.cfg_we_i) begin
        if (bus.cfg_addr_i == 6'h00) r_en   <= bus.cfg_wdata_i[N_SRC-1:0];
        if (bus.cfg_addr_i == 6'h01) r_mode <= bus.cfg_wdata_i[N_SRC-1:0];
        if (bus.cfg_addr_i == 6'h02) r_thr  <= bus.cfg_wdata_i[PRIO_W-1:0];
        for (int k = 0; k < N_SRC; k++)
          if (bus.cfg_addr_i == 6'(32 + k)) r_prio[k] <= bus.cfg_wdata_i[PRIO_W-1:0];
      end
    end
  end
  always_ff @(posedge clk_i) r_state <= reset_i ? IDLE : w_next;
  // ack beats withdrawal; a latched request is never preempted
  always_comb
    w_next = r_state == IDLE   ? (w_any ? ASSERT : IDLE) :
             r_state == ASSERT ? (bus.irq_ack_i ? SERVICE : (w_id_elig ? ASSERT : IDLE)) :
                                 (bus.complete_i ? IDLE : SERVICE);
  always_comb begin
    bus.meip_o      = r_state == ASSERT;
    bus.irq_id_o    = r_id;
    bus.pending_o   = r_pend;
    bus.cfg_rdata_o = r_rdata;
  end
endmodule
